// File: rtl/mips_mem_defs.sv
// mips_mem_defs: shared state encodings and streak width for the memory port arbiter.
package mips_mem_defs;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } ma_state_e;
    localparam int STREAK_W = 4;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch (I) and memory-stage (D) requests onto one unified memory port.
module mem_port_arbiter
    import mips_mem_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic             MA_CLK,
    input  logic             MA_RST,
    input  logic             MA_IReq,
    input  logic [WIDTH-1:0] MA_IAddr,
    input  logic             MA_DReq,
    input  logic             MA_DWe,
    input  logic [WIDTH-1:0] MA_DAddr,
    input  logic [WIDTH-1:0] MA_DWData,
    input  logic [WIDTH-1:0] MA_MemRData,
    input  logic             MA_MemRdy,
    output logic             MA_MemReq,
    output logic             MA_MemWe,
    output logic [WIDTH-1:0] MA_MemAddr,
    output logic [WIDTH-1:0] MA_MemWData,
    output logic [WIDTH-1:0] MA_IRData,
    output logic             MA_IValid,
    output logic [WIDTH-1:0] MA_DRData,
    output logic             MA_DValid,
    output logic             MA_StallF,
    output logic             MA_StallM
);
    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_DSTREAK);

    ma_state_e           state_q;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                ivalid_q, dvalid_q, we_q;
    logic [WIDTH-1:0]    addr_q, wdata_q, irdata_q, drdata_q;
    logic                i_elig, d_elig, grant_i, grant_d;

    // A requester whose Valid is pulsing is still holding Req for that one cycle; skip it.
    assign i_elig  = MA_IReq & ~ivalid_q;
    assign d_elig  = MA_DReq & ~dvalid_q;
    assign grant_i = i_elig & (~d_elig | (streak_q == MAX_S));
    assign grant_d = d_elig & ~grant_i;

    always_comb
        streak_d = (grant_i || !MA_IReq) ? '0 : (streak_q == MAX_S) ? MAX_S : streak_q + 1'b1;

    always_ff @(posedge MA_CLK) begin
        if (!MA_RST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q  <= IBUSY;
                        addr_q   <= MA_IAddr;
                        we_q     <= 1'b0;
                        streak_q <= streak_d;
                    end else if (grant_d) begin
                        state_q  <= DBUSY;
                        addr_q   <= MA_DAddr;
                        wdata_q  <= MA_DWData;
                        we_q     <= MA_DWe;
                        streak_q <= streak_d;
                    end
                end
                IBUSY: begin
                    if (MA_MemRdy) begin
                        irdata_q <= MA_MemRData;
                        ivalid_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                DBUSY: begin
                    if (MA_MemRdy) begin
                        if (!we_q) drdata_q <= MA_MemRData;
                        dvalid_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MA_MemReq   = state_q != IDLE;
    assign MA_MemWe    = (state_q == DBUSY) & we_q;
    assign MA_MemAddr  = addr_q;
    assign MA_MemWData = wdata_q;
    assign MA_IRData   = irdata_q;
    assign MA_IValid   = ivalid_q;
    assign MA_DRData   = drdata_q;
    assign MA_DValid   = dvalid_q;
    assign MA_StallF   = MA_IReq & ~ivalid_q;
    assign MA_StallM   = MA_DReq & ~dvalid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, streak limit, completion pulses and reset abandonment.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ireq, dreq, dwe, memrdy;
    logic [31:0] iaddr, daddr, dwdata, memrdata;
    logic        memreq, memwe, ivalid, dvalid, stallf, stallm;
    logic [31:0] memaddr, memwdata, irdata, drdata;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_port_arbiter #(.WIDTH(32), .MAX_DSTREAK(4)) dut (
        .MA_CLK(clk), .MA_RST(rst),
        .MA_IReq(ireq), .MA_IAddr(iaddr),
        .MA_DReq(dreq), .MA_DWe(dwe), .MA_DAddr(daddr), .MA_DWData(dwdata),
        .MA_MemRData(memrdata), .MA_MemRdy(memrdy),
        .MA_MemReq(memreq), .MA_MemWe(memwe), .MA_MemAddr(memaddr), .MA_MemWData(memwdata),
        .MA_IRData(irdata), .MA_IValid(ivalid), .MA_DRData(drdata), .MA_DValid(dvalid),
        .MA_StallF(stallf), .MA_StallM(stallm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; memrdy = 1'b0;
        iaddr = '0; daddr = '0; dwdata = '0; memrdata = '0;
        tick(); tick();
        chk("rst_memreq", 32'(memreq), 0);
        chk("rst_memwe", 32'(memwe), 0);
        chk("rst_ivalid", 32'(ivalid), 0);
        chk("rst_dvalid", 32'(dvalid), 0);
        chk("rst_irdata", irdata, 0);
        chk("rst_drdata", drdata, 0);
        chk("rst_memaddr", memaddr, 0);
        chk("rst_memwdata", memwdata, 0);
        rst = 1'b1;
        tick();

        // single fetch, memory ready on the second busy cycle
        ireq = 1'b1; iaddr = 32'h0000_0040;
        #1 chk("f_stallf_pre", 32'(stallf), 1);
        chk("f_memreq_pre", 32'(memreq), 0);
        tick();
        chk("f_memreq_c1", 32'(memreq), 1);
        chk("f_memaddr", memaddr, 32'h40);
        chk("f_memwe", 32'(memwe), 0);
        chk("f_stallf_c1", 32'(stallf), 1);
        tick();
        chk("f_memreq_c2", 32'(memreq), 1);
        memrdy = 1'b1; memrdata = 32'h8C02_0004;
        tick();
        chk("f_memreq_done", 32'(memreq), 0);
        chk("f_ivalid", 32'(ivalid), 1);
        chk("f_irdata", irdata, 32'h8C02_0004);
        chk("f_stallf_valid", 32'(stallf), 0);
        ireq = 1'b0; memrdy = 1'b0;
        tick();
        chk("f_ivalid_once", 32'(ivalid), 0);

        // load with memory ready in the first busy cycle; Req stays high through Valid
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h200; memrdy = 1'b1; memrdata = 32'h1111_2222;
        tick();
        chk("l_memreq", 32'(memreq), 1);
        chk("l_memaddr", memaddr, 32'h200);
        tick();
        chk("l_dvalid", 32'(dvalid), 1);
        chk("l_drdata", drdata, 32'h1111_2222);
        chk("l_memreq_done", 32'(memreq), 0);
        chk("l_stallm_valid", 32'(stallm), 0);
        tick();
        chk("l_no_dup", 32'(memreq), 0);
        chk("l_dvalid_once", 32'(dvalid), 0);
        chk("l_stallm_again", 32'(stallm), 1);
        dreq = 1'b0; memrdy = 1'b0;
        tick();
        chk("l_idle", 32'(memreq), 0);

        // simultaneous store and fetch: D first, then I; load data untouched
        ireq = 1'b1; iaddr = 32'h44; dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'hDEAD_BEEF;
        tick();
        chk("s_memwe", 32'(memwe), 1);
        chk("s_memaddr", memaddr, 32'h100);
        chk("s_memwdata", memwdata, 32'hDEAD_BEEF);
        memrdy = 1'b1; memrdata = 32'h5555_AAAA;
        tick();
        chk("s_dvalid", 32'(dvalid), 1);
        chk("s_drdata_hold", drdata, 32'h1111_2222);
        dreq = 1'b0; dwe = 1'b0; memrdy = 1'b0; memrdata = 32'h3333_4444;
        tick();
        chk("s_i_memreq", 32'(memreq), 1);
        chk("s_i_memaddr", memaddr, 32'h44);
        chk("s_i_memwe", 32'(memwe), 0);
        memrdy = 1'b1;
        tick();
        chk("s_i_ivalid", 32'(ivalid), 1);
        chk("s_i_irdata", irdata, 32'h3333_4444);
        chk("s_i_drdata", drdata, 32'h1111_2222);
        ireq = 1'b0; memrdy = 1'b0;
        tick();

        // streak: four D grants with I requesting, then I wins, then D resumes
        for (int k = 0; k < 4; k++) begin
            dreq = 1'b1; ireq = 1'b1; iaddr = 32'h48; daddr = 32'h300 + 32'(k);
            tick();
            chk($sformatf("k_dgrant%0d", k), memaddr, 32'h300 + 32'(k));
            ireq = 1'b0; memrdy = 1'b1;
            tick();
            chk($sformatf("k_dvalid%0d", k), 32'(dvalid), 1);
            memrdy = 1'b0;
            tick();
            chk($sformatf("k_gap%0d", k), 32'(memreq), 0);
        end
        ireq = 1'b1; daddr = 32'h304;
        tick();
        chk("k_igrant", memaddr, 32'h48);
        memrdy = 1'b1;
        tick();
        chk("k_ivalid", 32'(ivalid), 1);
        ireq = 1'b0; memrdy = 1'b0;
        tick();
        chk("k_dresume", memaddr, 32'h304);
        chk("k_dresume_req", 32'(memreq), 1);
        memrdy = 1'b1;
        tick();
        dreq = 1'b0; memrdy = 1'b0;
        tick();

        // reset mid-access abandons it
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h500; memrdata = 32'h7777_8888;
        tick();
        chk("r_busy", 32'(memreq), 1);
        rst = 1'b0;
        tick();
        chk("r_memreq", 32'(memreq), 0);
        chk("r_drdata", drdata, 0);
        rst = 1'b1; dreq = 1'b0; memrdy = 1'b1;
        tick();
        chk("r_dvalid", 32'(dvalid), 0);
        chk("r_memreq_after", 32'(memreq), 0);
        tick();
        chk("r_dvalid2", 32'(dvalid), 0);

        // MemRdy with no requests is ignored
        tick();
        chk("i_memreq", 32'(memreq), 0);
        chk("i_ivalid", 32'(ivalid), 0);
        chk("i_dvalid", 32'(dvalid), 0);
        memrdy = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data/address width.
REQ-002 SHALL have parameter MAX_DSTREAK, default 4: maximum consecutive D grants while I waits, range 1..15.
REQ-003 SHALL have port MA_CLK, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port MA_RST, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port MA_IReq, input, 1: fetch read request, level, held until MA_IValid.
REQ-006 SHALL have port MA_IAddr, input, WIDTH: fetch address (PC).
REQ-007 SHALL have port MA_DReq, input, 1: memory-stage request, level, held until MA_DValid.
REQ-008 SHALL have port MA_DWe, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port MA_DAddr, input, WIDTH: data address (ALU result).
REQ-010 SHALL have port MA_DWData, input, WIDTH: store data.
REQ-011 SHALL have port MA_MemRData, input, WIDTH: unified memory read data.
REQ-012 SHALL have port MA_MemRdy, input, 1: memory completes the current access.
REQ-013 SHALL have port MA_MemReq, output, 1: access active toward memory.
REQ-014 SHALL have port MA_MemWe, output, 1: memory write enable.
REQ-015 SHALL have port MA_MemAddr, output, WIDTH: memory address.
REQ-016 SHALL have port MA_MemWData, output, WIDTH: memory write data.
REQ-017 SHALL have port MA_IRData, output, WIDTH: fetched instruction.
REQ-018 SHALL have port MA_IValid, output, 1: one-cycle fetch completion pulse.
REQ-019 SHALL have port MA_DRData, output, WIDTH: load data.
REQ-020 SHALL have port MA_DValid, output, 1: one-cycle data completion pulse.
REQ-021 SHALL have port MA_StallF, output, 1: stall request for fetch/decode.
REQ-022 SHALL have port MA_StallM, output, 1: stall request for the whole pipeline.

Function
REQ-023 SHALL implement a three-state FSM: IDLE, IBUSY, DBUSY.
REQ-024 In IDLE, an eligible request SHALL be granted at the edge, and the FSM SHALL enter IBUSY or DBUSY, with address, data and we registered from the granted port.
REQ-025 MA_MemReq SHALL be 1 exactly in IBUSY and DBUSY; MA_MemWe SHALL be 1 only in DBUSY with registered we=1.
REQ-026 MA_MemAddr, MA_MemWData and MA_MemWe SHALL remain constant while busy.
REQ-027 Busy state SHALL persist until MA_MemRdy=1 is sampled; MA_MemRdy may be high in the first busy cycle (minimum 2-cycle access).
REQ-028 On MA_MemRdy=1 in IBUSY, MA_IRData SHALL capture MA_MemRData, MA_IValid SHALL be 1 for the next cycle, and the FSM SHALL return to IDLE.
REQ-029 On MA_MemRdy=1 in DBUSY, MA_DValid SHALL be 1 for the next cycle; MA_DRData SHALL capture only for loads and SHALL hold its prior value for stores.
REQ-030 A request SHALL be ineligible in the cycle its own Valid is 1, so no duplicate access occurs.
REQ-031 Priority SHALL be D over I, except I wins when streak == MAX_DSTREAK and both are eligible.
REQ-032 The 4-bit streak SHALL increment on a D grant while MA_IReq=1.
REQ-033 The streak SHALL clear on any I grant, or on a D grant while MA_IReq=0.
REQ-034 The streak SHALL saturate at MAX_DSTREAK.
REQ-035 MA_MemRdy in IDLE SHALL be ignored.
REQ-036 MA_StallF SHALL equal MA_IReq & ~MA_IValid; MA_StallM SHALL equal MA_DReq & ~MA_DValid (combinational from registered Valid).
REQ-037 Request changes while busy SHALL not affect the access in flight.

Reset
REQ-038 With MA_RST=0 at an edge, FSM=IDLE, streak=0, MA_IValid=0, MA_DValid=0, MA_IRData=0, MA_DRData=0, MA_MemAddr=0, MA_MemWData=0, MA_MemWe=0, MA_MemReq=0.
REQ-039 Reset mid-access SHALL abandon the access; a later MA_MemRdy SHALL be discarded and no Valid SHALL pulse.

Structure
REQ-040 State encodings (IDLE=2'b00, IBUSY=2'b01, DBUSY=2'b10) and the streak width SHALL live in a shared constants include file, mips_mem_defs.
REQ-041 The block SHALL be a single module with no sub-module; the streak counter is inline.

Verification
REQ-042 Reset, then IReq=1, IAddr=0x00000040, MemRdy high after 2 cycles, RData=0x8C020004 -> MemReq for 2 cycles; IRData=0x8C020004, IValid for 1 cycle; StallF 1 until Valid.
REQ-043 IReq and DReq rise together, DWe=1, DAddr=0x100, DWData=0xDEADBEEF -> D served first with MemWe=1, MemWData=0xDEADBEEF; I served next; DRData unchanged.
REQ-044 DReq held continuously with back-to-back loads, IReq=1, MAX_DSTREAK=4 -> exactly 4 D grants, then 1 I grant, then D resumes.
REQ-045 MemRdy=1 in the first busy cycle -> access 2 cycles; no duplicate grant in the Valid cycle while Req is still high.
REQ-046 MA_RST=0 in DBUSY, then MemRdy=1 after reset release -> DValid stays 0; MemReq=0; FSM=IDLE.
REQ-047 MemRdy pulsed in IDLE with no requests -> no Valid, no state change.
